// File: rtl/rotating_register_file.sv
// -----------------------------------------------------------------------------
// rotating_register_file
//
// Purpose:
//   Multi-ported register file for a CGRA processing element. NUM_WR write
//   ports and NUM_RD read ports share DEPTH = 2**LOG2REGS registers. Logical
//   addresses are offset by a rotating base pointer so that modulo-scheduled
//   loops can rename registers each iteration. Reads are registered (1-cycle
//   latency) and have per-port enables. Optional same-cycle write-to-read
//   bypass and a synchronous clear are provided.
//
// Ports:
//   CGRA_Clock   in   1                 clock, rising edge
//   CGRA_Reset   in   1                 asynchronous reset, active-high
//   WE           in   NUM_WR            write enable per port
//   address_in   in   NUM_WR*LOG2REGS   logical write address, port k at [k*LOG2REGS +: LOG2REGS]
//   in           in   NUM_WR*SIZE       write data, port k at [k*SIZE +: SIZE]
//   RE           in   NUM_RD            read enable per port
//   address_out  in   NUM_RD*LOG2REGS   logical read address, packed as above
//   out          out  NUM_RD*SIZE       registered read data, packed as above
//   rotate       in   1                 decrement base pointer (loop iteration boundary)
//   clear        in   1                 synchronous clear of registers and base
//   base         out  LOG2REGS          current rotating base pointer
// -----------------------------------------------------------------------------
module rotating_register_file #(
    parameter int NUM_WR   = 2,
    parameter int NUM_RD   = 4,
    parameter int LOG2REGS = 3,
    parameter int SIZE     = 32,
    parameter int BYPASS   = 0,
    parameter int ROTATE   = 1
) (
    input  logic                         CGRA_Clock,
    input  logic                         CGRA_Reset,
    input  logic [NUM_WR-1:0]            WE,
    input  logic [NUM_WR*LOG2REGS-1:0]   address_in,
    input  logic [NUM_WR*SIZE-1:0]       in,
    input  logic [NUM_RD-1:0]            RE,
    input  logic [NUM_RD*LOG2REGS-1:0]   address_out,
    output logic [NUM_RD*SIZE-1:0]       out,
    input  logic                         rotate,
    input  logic                         clear,
    output logic [LOG2REGS-1:0]          base
);

    localparam int DEPTH = 2 ** LOG2REGS;

    logic [SIZE-1:0]      r_regs [DEPTH];
    logic [LOG2REGS-1:0]  r_base;
    logic [NUM_RD*SIZE-1:0] r_out;

    logic [LOG2REGS-1:0]  w_wr_phys [NUM_WR];
    logic [LOG2REGS-1:0]  w_rd_phys [NUM_RD];
    logic [DEPTH-1:0]     w_wr_hit;
    logic [SIZE-1:0]      w_wr_data [DEPTH];
    logic [SIZE-1:0]      w_rd_data [NUM_RD];

    // Logical-to-physical mapping; the LOG2REGS-wide sum wraps modulo DEPTH.
    always_comb begin
        for (int k = 0; k < NUM_WR; k++) begin
            w_wr_phys[k] = address_in[k*LOG2REGS +: LOG2REGS] + r_base;
        end
        for (int j = 0; j < NUM_RD; j++) begin
            w_rd_phys[j] = address_out[j*LOG2REGS +: LOG2REGS] + r_base;
        end
    end

    // Per-register write resolution. Ports are scanned in ascending order so
    // the highest-numbered enabled port targeting a register wins.
    always_comb begin
        for (int d = 0; d < DEPTH; d++) begin
            w_wr_hit[d]  = 1'b0;
            w_wr_data[d] = '0;
            for (int k = 0; k < NUM_WR; k++) begin
                if (WE[k] && (w_wr_phys[k] == LOG2REGS'(d))) begin
                    w_wr_hit[d]  = 1'b1;
                    w_wr_data[d] = in[k*SIZE +: SIZE];
                end
            end
        end
    end

    // Read mux. With bypass enabled the resolved write data is forwarded,
    // including in a clear cycle where the write itself is discarded.
    always_comb begin
        for (int j = 0; j < NUM_RD; j++) begin
            if ((BYPASS != 0) && w_wr_hit[w_rd_phys[j]]) begin
                w_rd_data[j] = w_wr_data[w_rd_phys[j]];
            end else begin
                w_rd_data[j] = r_regs[w_rd_phys[j]];
            end
        end
    end

    // Register array; clear has priority over all writes.
    always_ff @(posedge CGRA_Clock or posedge CGRA_Reset) begin
        if (CGRA_Reset) begin
            for (int d = 0; d < DEPTH; d++) begin
                r_regs[d] <= '0;
            end
        end else if (clear) begin
            for (int d = 0; d < DEPTH; d++) begin
                r_regs[d] <= '0;
            end
        end else begin
            for (int d = 0; d < DEPTH; d++) begin
                if (w_wr_hit[d]) begin
                    r_regs[d] <= w_wr_data[d];
                end
            end
        end
    end

    // Base pointer: decrements (wrapping) on rotate; clear overrides rotate.
    always_ff @(posedge CGRA_Clock or posedge CGRA_Reset) begin
        if (CGRA_Reset) begin
            r_base <= '0;
        end else if (clear) begin
            r_base <= '0;
        end else if ((ROTATE != 0) && rotate) begin
            r_base <= r_base - 1'b1;
        end
    end

    // Registered read lanes; a disabled lane holds its last value. Reads in a
    // clear cycle still capture the pre-clear contents.
    always_ff @(posedge CGRA_Clock or posedge CGRA_Reset) begin
        if (CGRA_Reset) begin
            r_out <= '0;
        end else begin
            for (int j = 0; j < NUM_RD; j++) begin
                if (RE[j]) begin
                    r_out[j*SIZE +: SIZE] <= w_rd_data[j];
                end
            end
        end
    end

    assign out  = r_out;
    assign base = r_base;

endmodule

// File: tb/tb_rotating_register_file.sv
// -----------------------------------------------------------------------------
// tb_rotating_register_file
//
// Purpose:
//   Directed bench for rotating_register_file. Two instances share the same
//   stimulus: dut_a with default parameters (BYPASS=0, ROTATE=1) and dut_b
//   with BYPASS=1, ROTATE=0. A behavioural model of both configurations is
//   compared against every output on each falling edge, and hand-computed
//   literal expectations pin the model at key points.
// -----------------------------------------------------------------------------
module tb_rotating_register_file;

    localparam int NWR = 2;
    localparam int NRD = 4;
    localparam int LG  = 3;
    localparam int DEP = 8;
    localparam int SZ  = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;

    // Unpacked stimulus, packed onto the DUT buses below.
    logic          we   [NWR];
    logic [LG-1:0] ain  [NWR];
    logic [SZ-1:0] din  [NWR];
    logic          re   [NRD];
    logic [LG-1:0] aout [NRD];
    logic          rot;
    logic          clr;

    logic [NWR-1:0]    we_bus;
    logic [NWR*LG-1:0] ain_bus;
    logic [NWR*SZ-1:0] din_bus;
    logic [NRD-1:0]    re_bus;
    logic [NRD*LG-1:0] aout_bus;

    logic [NRD*SZ-1:0] out_a, out_b;
    logic [LG-1:0]     base_a, base_b;

    int n_pass = 0;
    int n_tot  = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < NWR; k++) begin
            we_bus[k]            = we[k];
            ain_bus[k*LG +: LG]  = ain[k];
            din_bus[k*SZ +: SZ]  = din[k];
        end
        for (int j = 0; j < NRD; j++) begin
            re_bus[j]            = re[j];
            aout_bus[j*LG +: LG] = aout[j];
        end
    end

    rotating_register_file #(
        .NUM_WR(NWR), .NUM_RD(NRD), .LOG2REGS(LG), .SIZE(SZ), .BYPASS(0), .ROTATE(1)
    ) dut_a (
        .CGRA_Clock(clk), .CGRA_Reset(rst), .WE(we_bus), .address_in(ain_bus),
        .in(din_bus), .RE(re_bus), .address_out(aout_bus), .out(out_a),
        .rotate(rot), .clear(clr), .base(base_a)
    );

    rotating_register_file #(
        .NUM_WR(NWR), .NUM_RD(NRD), .LOG2REGS(LG), .SIZE(SZ), .BYPASS(1), .ROTATE(0)
    ) dut_b (
        .CGRA_Clock(clk), .CGRA_Reset(rst), .WE(we_bus), .address_in(ain_bus),
        .in(din_bus), .RE(re_bus), .address_out(aout_bus), .out(out_b),
        .rotate(rot), .clear(clr), .base(base_b)
    );

    // ---------------- behavioural model (index 0 = dut_a, 1 = dut_b) -------
    logic [SZ-1:0] m_mem  [2][DEP];
    int            m_base [2];
    logic [SZ-1:0] m_out  [2][NRD];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                m_base[c] = 0;
                for (int d = 0; d < DEP; d++) m_mem[c][d] = '0;
                for (int j = 0; j < NRD; j++) m_out[c][j] = '0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                logic [SZ-1:0] pend_v [DEP];
                bit            pend_h [DEP];
                int            p;
                for (int d = 0; d < DEP; d++) begin
                    pend_h[d] = 1'b0;
                    pend_v[d] = '0;
                end
                // Later ports overwrite earlier ones: highest enabled port wins.
                for (int k = 0; k < NWR; k++) begin
                    if (we[k]) begin
                        p = (int'(ain[k]) + m_base[c]) % DEP;
                        pend_h[p] = 1'b1;
                        pend_v[p] = din[k];
                    end
                end
                for (int j = 0; j < NRD; j++) begin
                    if (re[j]) begin
                        p = (int'(aout[j]) + m_base[c]) % DEP;
                        if (c == 1 && pend_h[p]) m_out[c][j] = pend_v[p];
                        else                     m_out[c][j] = m_mem[c][p];
                    end
                end
                if (clr) begin
                    for (int d = 0; d < DEP; d++) m_mem[c][d] = '0;
                    m_base[c] = 0;
                end else begin
                    for (int d = 0; d < DEP; d++) if (pend_h[d]) m_mem[c][d] = pend_v[d];
                    if (c == 0 && rot) m_base[c] = (m_base[c] + DEP - 1) % DEP;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [SZ-1:0] got, input logic [SZ-1:0] exp);
        n_tot++;
        if (got !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        else n_pass++;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int j = 0; j < NRD; j++) begin
                chk($sformatf("model_out%0d_a", j), out_a[j*SZ +: SZ], m_out[0][j]);
                chk($sformatf("model_out%0d_b", j), out_b[j*SZ +: SZ], m_out[1][j]);
            end
            chk("model_base_a", SZ'(base_a), SZ'(m_base[0]));
            chk("model_base_b", SZ'(base_b), SZ'(m_base[1]));
        end
    end

    // ---------------- stimulus helpers ------------------------------------
    task automatic idle();
        for (int k = 0; k < NWR; k++) begin we[k] = 1'b0; ain[k] = '0; din[k] = '0; end
        for (int j = 0; j < NRD; j++) begin re[j] = 1'b0; aout[j] = '0; end
        rot = 1'b0;
        clr = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [SZ-1:0] lane(input logic [NRD*SZ-1:0] bus, input int j);
        return bus[j*SZ +: SZ];
    endfunction

    initial begin
        idle();
        // 1: reset then idle
        #1 rst = 1'b1;
        chk_en = 1'b1;
        #11 rst = 1'b0;
        tick();
        for (int j = 0; j < NRD; j++) chk("reset_out_a", lane(out_a, j), 32'h0);
        chk("reset_base_a", SZ'(base_a), 32'h0);
        chk("reset_base_b", SZ'(base_b), 32'h0);
        for (int j = 0; j < NRD; j++) begin re[j] = 1'b1; aout[j] = LG'(j * 3 + 1); end
        tick();
        for (int j = 0; j < NRD; j++) chk("idle_read_zero_a", lane(out_a, j), 32'h0);

        // 2: basic write then read, then hold with RE=0
        idle();
        we[0] = 1'b1; ain[0] = 3'd3; din[0] = 32'hDEADBEEF;
        tick();
        idle();
        re[0] = 1'b1; aout[0] = 3'd3;
        tick();
        chk("basic_rd_a", lane(out_a, 0), 32'hDEADBEEF);
        chk("basic_rd_b", lane(out_b, 0), 32'hDEADBEEF);
        idle();
        we[0] = 1'b1; ain[0] = 3'd3; din[0] = 32'h00001234;
        tick();
        chk("hold_a", lane(out_a, 0), 32'hDEADBEEF);

        // 3: write-write conflict, port 1 wins
        idle();
        we[0] = 1'b1; ain[0] = 3'd5; din[0] = 32'h11;
        we[1] = 1'b1; ain[1] = 3'd5; din[1] = 32'h22;
        tick();
        idle();
        re[1] = 1'b1; aout[1] = 3'd5;
        tick();
        chk("conflict_a", lane(out_a, 1), 32'h22);

        // 4: read-during-write, with and without bypass
        idle();
        we[0] = 1'b1; ain[0] = 3'd2; din[0] = 32'h7;
        tick();
        idle();
        we[0] = 1'b1; ain[0] = 3'd2; din[0] = 32'h55;
        re[2] = 1'b1; aout[2] = 3'd2;
        tick();
        chk("rdw_nobypass_a", lane(out_a, 2), 32'h7);
        chk("rdw_bypass_b", lane(out_b, 2), 32'h55);
        idle();
        we[0] = 1'b1; ain[0] = 3'd6; din[0] = 32'hAA;
        we[1] = 1'b1; ain[1] = 3'd6; din[1] = 32'hBB;
        re[3] = 1'b1; aout[3] = 3'd6;
        tick();
        chk("rdw_conflict_a", lane(out_a, 3), 32'h0);
        chk("rdw_conflict_b", lane(out_b, 3), 32'hBB);

        // 5: rotation
        idle();
        we[0] = 1'b1; ain[0] = 3'd0; din[0] = 32'hA;
        tick();
        idle();
        rot = 1'b1;
        tick();
        chk("rot_base_a", SZ'(base_a), 32'd7);
        chk("rot_base_b", SZ'(base_b), 32'd0);
        idle();
        re[0] = 1'b1; aout[0] = 3'd1;
        tick();
        chk("rot_read_a", lane(out_a, 0), 32'hA);
        for (int i = 0; i < 7; i++) begin
            idle();
            rot = 1'b1;
            // write in a rotate cycle lands at the old base
            if (i == 2) begin we[1] = 1'b1; ain[1] = 3'd7; din[1] = 32'h77; end
            tick();
        end
        chk("rot_wrap_a", SZ'(base_a), 32'd0);
        chk("rot_fixed_b", SZ'(base_b), 32'd0);

        // 6: fill, then clear with a concurrent write, read and rotate
        for (int a = 0; a < DEP; a += 2) begin
            idle();
            we[0] = 1'b1; ain[0] = LG'(a);     din[0] = 32'h100 + a;
            we[1] = 1'b1; ain[1] = LG'(a + 1); din[1] = 32'h100 + a + 1;
            tick();
        end
        idle();
        clr = 1'b1; rot = 1'b1;
        we[0] = 1'b1; ain[0] = 3'd1; din[0] = 32'h999;
        re[0] = 1'b1; aout[0] = 3'd4;
        re[1] = 1'b1; aout[1] = 3'd1;
        tick();
        chk("clr_old_reg4_a", lane(out_a, 0), 32'h104);
        chk("clr_old_reg4_b", lane(out_b, 0), 32'h104);
        chk("clr_rd1_a", lane(out_a, 1), 32'h101);
        chk("clr_bypass_b", lane(out_b, 1), 32'h999);
        chk("clr_base_a", SZ'(base_a), 32'd0);
        idle();
        for (int j = 0; j < NRD; j++) begin re[j] = 1'b1; aout[j] = LG'(j * 2 + 1); end
        tick();
        for (int j = 0; j < NRD; j++) chk("clr_zero_a", lane(out_a, j), 32'h0);

        // mid-operation asynchronous reset
        idle();
        we[0] = 1'b1; ain[0] = 3'd3; din[0] = 32'h5A;
        tick();
        idle();
        re[0] = 1'b1; aout[0] = 3'd3; rot = 1'b1;
        tick();
        chk("pre_rst_a", lane(out_a, 0), 32'h5A);
        idle();
        rst = 1'b1;
        #2;
        chk("async_rst_out_a", lane(out_a, 0), 32'h0);
        chk("async_rst_out_b", lane(out_b, 0), 32'h0);
        chk("async_rst_base_a", SZ'(base_a), 32'd0);
        rst = 1'b0;
        re[0] = 1'b1; aout[0] = 3'd3;
        tick();
        chk("post_rst_rd_a", lane(out_a, 0), 32'h0);
        idle();
        we[0] = 1'b1; ain[0] = 3'd3; din[0] = 32'h66;
        tick();
        idle();
        re[0] = 1'b1; aout[0] = 3'd3;
        tick();
        chk("post_rst_wr_a", lane(out_a, 0), 32'h66);
        idle();
        tick();
        tick();
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
